// File: rtl/fractal_mem_pkg.sv
// Shared definitions for the fractal renderer's frame-buffer write path.
// Holds the default bus widths, the layout of a queued write, and a small
// helper for sizing index fields.

package fractal_mem_pkg;

   // Default widths of a frame-buffer write.
   localparam int FM_DATA_WIDTH = 16;
   localparam int FM_ADDR_WIDTH = 32;

   // One queued memory write. Address sits in the upper bits so that a
   // flattened word reads {addr, data}.
   typedef struct packed {
      logic [FM_ADDR_WIDTH-1:0] addr;
      logic [FM_DATA_WIDTH-1:0] data;
   } write_req_t;

   // Width of an index able to name n items. Never narrower than one bit,
   // so a single-item case still gets a legal vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy.
// Push is ignored while full and pop is ignored while empty, so the caller
// may drive either strobe freely. The head word reads as zero while empty.

module sync_fifo
   import fractal_mem_pkg::*;
#(
   parameter  int WIDTH = FM_ADDR_WIDTH + FM_DATA_WIDTH,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers wrap naturally when they overflow.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: state registers take non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write.
   always_ff @(posedge clock) begin
      // NOTE: the array is deliberately left without reset; occupancy and
      // the zeroed head below already hide stale contents, and a reset would
      // prevent the array from mapping onto plain storage.
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head = empty ? '0 : mem[rd_ptr];

   // Occupancy can never exceed the physical depth.
   a_count_bounded: assert property (
      @(posedge clock) disable iff (reset) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/write_arbiter_rr.sv
// N-to-1 write arbiter between the per-pixel solvers and the frame-buffer
// write port. One solver is accepted per cycle, by round robin or fixed
// priority, and its word is queued in an output FIFO so acceptance keeps
// going while the memory side stalls.
//
// in_ack depends only on in_valid, the round-robin pointer and the queue
// occupancy; there is no combinational path from out_ack to in_ack, so a
// full queue refuses a word even on a cycle where memory drains an entry.

module write_arbiter_rr
   import fractal_mem_pkg::*;
#(
   parameter  int NUM_SOLVERS = 2,
   parameter  int DATA_WIDTH  = FM_DATA_WIDTH,
   parameter  int ADDR_WIDTH  = FM_ADDR_WIDTH,
   parameter  int FIFO_DEPTH  = 4,
   parameter  int RR_MODE     = 1,
   localparam int IDX_W       = idx_width(NUM_SOLVERS),
   localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_SOLVERS-1:0][DATA_WIDTH-1:0] in_data,
   input  logic [NUM_SOLVERS-1:0][ADDR_WIDTH-1:0] in_addr,
   input  logic [NUM_SOLVERS-1:0]                 in_valid,
   output logic [NUM_SOLVERS-1:0]                 in_ack,
   output logic [DATA_WIDTH-1:0]                  out_data,
   output logic [ADDR_WIDTH-1:0]                  out_addr,
   output logic                                   out_write_en,
   input  logic                                   out_ack,
   output logic [CNT_W-1:0]                       fifo_count,
   output logic [IDX_W-1:0]                       grant_idx
);

   localparam bit USE_RR = (RR_MODE != 0);

   // Queued word; same {addr, data} layout as write_req_t, sized by the
   // parameters of this instance.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } word_t;

   logic [IDX_W-1:0] rr_ptr;     // last solver granted
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] cand;
   logic             found;
   logic             can_push;
   logic             grant;
   logic             fifo_full;
   logic             fifo_empty;
   word_t            push_word;
   word_t            head_word;

   // Reset also masks the grant, so nothing is acked or queued while the
   // block is held in reset.
   assign can_push = ~fifo_full;
   assign grant    = ~reset & can_push & (|in_valid);

   // Winner search: upward from the slot after the last grant in round
   // robin, upward from zero in fixed priority.
   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_SOLVERS; k++) begin
         if (USE_RR) begin
            cand = IDX_W'((int'(rr_ptr) + 1 + k) % NUM_SOLVERS);
         end else begin
            cand = IDX_W'(k);
         end
         if (!found && in_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // One-hot acknowledge to the winning solver.
   always_comb begin
      in_ack = '0;
      if (grant) begin
         in_ack[winner] = 1'b1;
      end
   end

   assign grant_idx = winner;

   // Round-robin pointer; moves only on a cycle that actually grants. The
   // reset value makes the first search start at solver 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr <= IDX_W'(NUM_SOLVERS - 1);
      end else if (grant && USE_RR) begin
         rr_ptr <= winner;
      end
   end

   assign push_word.addr = in_addr[winner];
   assign push_word.data = in_data[winner];

   sync_fifo #(
      .WIDTH ($bits(word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (grant),
      .push_data (push_word),
      .pop       (out_ack),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (head_word)
   );

   // The head is held in storage until popped, so out_* stay stable while
   // memory stalls; an empty queue presents zeros.
   assign out_write_en = ~fifo_empty;
   assign out_data     = head_word.data;
   assign out_addr     = head_word.addr;

   // At most one solver is acknowledged per cycle.
   a_grant_onehot: assert property (
      @(posedge clock) disable iff (reset) $onehot0(in_ack));

   // A full queue never acknowledges, whatever out_ack does.
   a_no_grant_when_full: assert property (
      @(posedge clock) disable iff (reset) fifo_full |-> (in_ack == '0));

endmodule
